// File: rtl/trap_sequencer_if.sv
// Commit and redirect bus between trap_sequencer, the CSR unit and fetch.
//   traped/mret     : one-cycle commit pulses to the CSR unit
//   ecp/trap_cause/interupt : commit payload (valid while traped is high)
//   redirect_valid/redirect_pc/redirect_ready : fetch redirect handshake
// master = trap_sequencer, slave = CSR unit / fetch side.
interface trap_sequencer_if;
  logic        traped;
  logic        mret;
  logic [31:0] ecp;
  logic [3:0]  trap_cause;
  logic        interupt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output traped, mret, ecp, trap_cause, interupt, redirect_valid, redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  traped, mret, ecp, trap_cause, interupt, redirect_valid, redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates exceptions, mret and interrupts, drains and
// flushes the pipeline, pulses a commit to the CSR unit and then redirects
// fetch to the CSR-supplied vector.
// Ports:
//   clk, reset (async, active low)
//   exc_valid/exc_cause/exc_pc, mret_valid, next_pc, eip/tip/sip : event sources
//   pipe_empty                  : pipeline drained indication
//   trap_vector, mret_vector    : redirect targets from the CSR unit
//   stall, flush, busy          : pipeline control / status
//   trap_count                  : saturating count of trap commits
//   csr_fetch                   : commit pulse + fetch redirect handshake
// Optional feature: define TRAP_SEQ_COUNT_EN to enable trap_count; otherwise
// trap_count is tied to 0.
module trap_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    exc_valid,
  input  logic [3:0]              exc_cause,
  input  logic [31:0]             exc_pc,
  input  logic                    mret_valid,
  input  logic [31:0]             next_pc,
  input  logic                    eip,
  input  logic                    tip,
  input  logic                    sip,
  input  logic                    pipe_empty,
  input  logic [31:0]             trap_vector,
  input  logic [31:0]             mret_vector,
  output logic                    stall,
  output logic                    flush,
  output logic                    busy,
  output logic [15:0]             trap_count,
  trap_sequencer_if.master        csr_fetch
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CAUSE_W = 4;
  localparam logic [CNT_W-1:0] DRAIN_MAX = CNT_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                 kind_mret_q, kind_mret_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 int_q, int_d;

  logic                 stall_q, stall_d;
  logic                 flush_q, flush_d;
  logic                 busy_q, busy_d;
  logic                 traped_q, traped_d;
  logic                 mret_q, mret_d;
  logic [PC_W-1:0]      ecp_q, ecp_d;
  logic [CAUSE_W-1:0]   tcause_q, tcause_d;
  logic                 tint_q, tint_d;
  logic                 rvalid_q, rvalid_d;

  // Next state, event latch and next registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kind_mret_d = kind_mret_q;
    cause_d     = cause_q;
    pc_d        = pc_q;
    int_d       = int_q;
    // Count of DRAIN cycles completed including the current one, saturating.
    cnt_inc     = (cnt_q >= DRAIN_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (exc_valid) begin
          kind_mret_d = 1'b0;
          cause_d     = exc_cause;
          pc_d        = exc_pc;
          int_d       = 1'b0;
        end else if (mret_valid) begin
          kind_mret_d = 1'b1;
          cause_d     = '0;
          pc_d        = '0;
          int_d       = 1'b0;
        end else if (eip) begin
          kind_mret_d = 1'b0;
          cause_d     = CAUSE_W'(11);
          pc_d        = next_pc;
          int_d       = 1'b1;
        end else if (sip) begin
          kind_mret_d = 1'b0;
          cause_d     = CAUSE_W'(3);
          pc_d        = next_pc;
          int_d       = 1'b1;
        end else if (tip) begin
          kind_mret_d = 1'b0;
          cause_d     = CAUSE_W'(7);
          pc_d        = next_pc;
          int_d       = 1'b1;
        end
        if (exc_valid || mret_valid || eip || sip || tip) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if ((cnt_inc >= DRAIN_MAX) && pipe_empty) state_d = COMMIT;
      end
      COMMIT:   state_d = REDIRECT;
      REDIRECT: if (csr_fetch.redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    stall_d  = (state_d != IDLE);
    busy_d   = (state_d != IDLE);
    flush_d  = (state_d == DRAIN);
    traped_d = (state_d == COMMIT) && !kind_mret_d;
    mret_d   = (state_d == COMMIT) &&  kind_mret_d;
    ecp_d    = traped_d ? pc_d    : '0;
    tcause_d = traped_d ? cause_d : '0;
    tint_d   = traped_d ? int_d   : 1'b0;
    rvalid_d = (state_d == REDIRECT);
  end

  // State, event latch and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kind_mret_q <= 1'b0;
      cause_q     <= '0;
      pc_q        <= '0;
      int_q       <= 1'b0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      traped_q    <= 1'b0;
      mret_q      <= 1'b0;
      ecp_q       <= '0;
      tcause_q    <= '0;
      tint_q      <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kind_mret_q <= kind_mret_d;
      cause_q     <= cause_d;
      pc_q        <= pc_d;
      int_q       <= int_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      traped_q    <= traped_d;
      mret_q      <= mret_d;
      ecp_q       <= ecp_d;
      tcause_q    <= tcause_d;
      tint_q      <= tint_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign stall                = stall_q;
  assign flush                = flush_q;
  assign busy                 = busy_q;
  assign csr_fetch.traped     = traped_q;
  assign csr_fetch.mret       = mret_q;
  assign csr_fetch.ecp        = ecp_q;
  assign csr_fetch.trap_cause = tcause_q;
  assign csr_fetch.interupt   = tint_q;
  assign csr_fetch.redirect_valid = rvalid_q;
  // Vector is followed live: the CSR unit updates it on the COMMIT edge.
  assign csr_fetch.redirect_pc = rvalid_q ? (kind_mret_q ? mret_vector : trap_vector) : '0;

`ifdef TRAP_SEQ_COUNT_EN
  logic [15:0] trap_count_q;

  // Saturating count of trap commits, bumped on the edge that ends COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_count_q <= '0;
    end else if (traped_q && (trap_count_q != 16'hffff)) begin
      trap_count_q <= trap_count_q + 16'd1;
    end
  end

  assign trap_count = trap_count_q;
`else
  assign trap_count = '0;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

  localparam int DRAIN = 2;
  localparam logic [31:0] TVEC = 32'h0000_0080;
  localparam logic [31:0] MVEC = 32'h0000_0344;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        mret_valid;
  logic [31:0] next_pc;
  logic        eip, tip, sip;
  logic        pipe_empty;
  logic [31:0] trap_vector;
  logic [31:0] mret_vector;
  logic        stall, flush, busy;
  logic [15:0] trap_count;
  logic        ready;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Behavioural model: an accepted event is described by the cycle it
  // entered draining (m_acc) and the cycle of its commit (m_com, -1 until
  // known). Cycle numbers count rising edges.
  bit          m_active;
  int          m_n;
  int          m_acc;
  int          m_com;
  bit          m_is_mret;
  logic [3:0]  m_cause;
  logic [31:0] m_pc;
  bit          m_int;
  int          m_count;

  always #5 clk = ~clk;

  trap_sequencer_if bus ();
  assign bus.redirect_ready = ready;

  trap_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk         (clk),
    .reset       (reset),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause),
    .exc_pc      (exc_pc),
    .mret_valid  (mret_valid),
    .next_pc     (next_pc),
    .eip         (eip),
    .tip         (tip),
    .sip         (sip),
    .pipe_empty  (pipe_empty),
    .trap_vector (trap_vector),
    .mret_vector (mret_vector),
    .stall       (stall),
    .flush       (flush),
    .busy        (busy),
    .trap_count  (trap_count),
    .csr_fetch   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_n);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_com    = -1;
    m_count  = 0;
  endtask

  task automatic accept(input bit is_mret, input logic [3:0] cause,
                        input logic [31:0] pc, input bit intr);
    m_active  = 1'b1;
    m_acc     = m_n;
    m_com     = -1;
    m_is_mret = is_mret;
    m_cause   = cause;
    m_pc      = pc;
    m_int     = intr;
  endtask

  // Advance the model over one rising edge using the inputs sampled there.
  task automatic model_edge();
    m_n++;
    if (!reset) begin
      model_reset();
    end else if (!m_active) begin
      if (exc_valid)       accept(1'b0, exc_cause, exc_pc, 1'b0);
      else if (mret_valid) accept(1'b1, 4'd0, 32'd0, 1'b0);
      else if (eip)        accept(1'b0, 4'd11, next_pc, 1'b1);
      else if (sip)        accept(1'b0, 4'd3,  next_pc, 1'b1);
      else if (tip)        accept(1'b0, 4'd7,  next_pc, 1'b1);
    end else if (m_com < 0) begin
      if ((m_n - m_acc) >= DRAIN && pipe_empty) m_com = m_n;
    end else if (m_n - 1 == m_com) begin
      if (!m_is_mret && m_count < 65535) m_count++;
    end else if (ready) begin
      m_active = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef TRAP_SEQ_COUNT_EN
    return 32'(m_count);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_all();
    bit drain, commit, redir;
    if (!reset) begin
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst flush", 32'(flush), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst traped", 32'(bus.traped), 32'd0);
      chk("rst mret", 32'(bus.mret), 32'd0);
      chk("rst ecp", bus.ecp, 32'd0);
      chk("rst cause", 32'(bus.trap_cause), 32'd0);
      chk("rst interupt", 32'(bus.interupt), 32'd0);
      chk("rst redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rst redirect_pc", bus.redirect_pc, 32'd0);
      chk("rst trap_count", 32'(trap_count), 32'd0);
    end else begin
      drain  = m_active && (m_com < 0);
      commit = m_active && (m_com == m_n);
      redir  = m_active && (m_com >= 0) && (m_n > m_com);
      chk("stall", 32'(stall), 32'(m_active));
      chk("busy", 32'(busy), 32'(m_active));
      chk("flush", 32'(flush), 32'(drain));
      chk("traped", 32'(bus.traped), 32'(commit && !m_is_mret));
      chk("mret", 32'(bus.mret), 32'(commit && m_is_mret));
      chk("redirect_valid", 32'(bus.redirect_valid), 32'(redir));
      if (commit) begin
        chk("ecp", bus.ecp, m_is_mret ? 32'd0 : m_pc);
        chk("trap_cause", 32'(bus.trap_cause), m_is_mret ? 32'd0 : 32'(m_cause));
        chk("interupt", 32'(bus.interupt), m_is_mret ? 32'd0 : 32'(m_int));
      end
      if (redir) chk("redirect_pc", bus.redirect_pc, m_is_mret ? mret_vector : trap_vector);
      chk("trap_count", 32'(trap_count), exp_count());
    end
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) check_all();
    end
  end

  // One clock: model follows the edge, inputs change 2 time units later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic clear_events();
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    eip        = 1'b0;
    tip        = 1'b0;
    sip        = 1'b0;
  endtask

  // Caller has set the event inputs; pipe_empty and ready are held 1.
  task automatic run_event(input string tag, input bit is_mret, input logic [3:0] cause,
                           input logic [31:0] pc, input bit intr);
    cyc();
    clear_events();
    cyc();
    @(negedge clk);
    chk({tag, " drain flush"}, 32'(flush), 32'd1);
    cyc();
    @(negedge clk);
    chk({tag, " traped"}, 32'(bus.traped), 32'(!is_mret));
    chk({tag, " mret"}, 32'(bus.mret), 32'(is_mret));
    if (!is_mret) begin
      chk({tag, " cause"}, 32'(bus.trap_cause), 32'(cause));
      chk({tag, " ecp"}, bus.ecp, pc);
      chk({tag, " int"}, 32'(bus.interupt), 32'(intr));
    end
    cyc();
    @(negedge clk);
    chk({tag, " redirect_valid"}, 32'(bus.redirect_valid), 32'd1);
    chk({tag, " redirect_pc"}, bus.redirect_pc, is_mret ? MVEC : TVEC);
    cyc();
    @(negedge clk);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    clear_events();
    exc_cause   = 4'd0;
    exc_pc      = 32'd0;
    next_pc     = 32'd0;
    pipe_empty  = 1'b1;
    ready       = 1'b1;
    trap_vector = TVEC;
    mret_vector = MVEC;
    m_n         = 0;
    m_acc       = 0;
    m_is_mret   = 1'b0;
    m_cause     = 4'd0;
    m_pc        = 32'd0;
    m_int       = 1'b0;
    model_reset();

    cyc();
    cyc();
    reset = 1'b1;
    cyc();

    // Exception with immediate drain.
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100;
    run_event("exc", 1'b0, 4'd2, 32'h100, 1'b0);

    // Interrupt priority.
    eip = 1'b1; tip = 1'b1; sip = 1'b1; next_pc = 32'h200;
    run_event("irq_all", 1'b0, 4'd11, 32'h200, 1'b1);
    tip = 1'b1;
    run_event("irq_tip", 1'b0, 4'd7, 32'h200, 1'b1);
    sip = 1'b1; tip = 1'b1;
    run_event("irq_sip_tip", 1'b0, 4'd3, 32'h200, 1'b1);

    // Exception beats mret; then mret alone.
    exc_valid = 1'b1; mret_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h300;
    run_event("exc_mret", 1'b0, 4'd5, 32'h300, 1'b0);
    mret_valid = 1'b1;
    run_event("mret", 1'b1, 4'd0, 32'd0, 1'b0);

    // Drain wait, then a slow redirect handshake.
    exc_valid = 1'b1; exc_cause = 4'd4; exc_pc = 32'h444; pipe_empty = 1'b0;
    cyc();
    clear_events();
    for (int i = 0; i < 6; i++) begin
      cyc();
      @(negedge clk);
      chk("wait flush", 32'(flush), 32'd1);
      chk("wait traped", 32'(bus.traped), 32'd0);
    end
    cyc();
    pipe_empty = 1'b1;
    ready      = 1'b0;
    cyc();
    @(negedge clk);
    chk("wait commit", 32'(bus.traped), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("hs valid", 32'(bus.redirect_valid), 32'd1);
      chk("hs pc", bus.redirect_pc, TVEC);
      chk("hs busy", 32'(busy), 32'd1);
    end
    cyc();
    ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("hs idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of DRAIN.
    exc_valid = 1'b1; exc_cause = 4'd1; exc_pc = 32'h500; pipe_empty = 1'b0;
    cyc();
    clear_events();
    cyc();
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async rst stall", 32'(stall), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst trap_count", 32'(trap_count), 32'd0);
    cyc();
    cyc();
    reset      = 1'b1;
    pipe_empty = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      @(negedge clk);
      chk("post rst traped", 32'(bus.traped), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      exc_valid  = ($urandom_range(0, 9) == 0);
      exc_cause  = 4'($urandom_range(0, 15));
      exc_pc     = $urandom;
      mret_valid = ($urandom_range(0, 9) == 0);
      next_pc    = $urandom;
      eip        = ($urandom_range(0, 11) == 0);
      tip        = ($urandom_range(0, 11) == 0);
      sip        = ($urandom_range(0, 11) == 0);
      pipe_empty = ($urandom_range(0, 2) != 0);
      ready      = ($urandom_range(0, 1) != 0);
    end

    @(posedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sequences every control-flow event (synchronous exception, pending interrupt, mret) into the CSR unit and the fetch stage.
- Sits between writeback, the CSR unit and fetch.
  - Arbitrates the event sources.
  - Stalls and flushes the pipeline until it drains.
  - Issues a single-cycle commit pulse to the CSR unit (traped/mret with ecp, cause and interrupt flag).
  - Redirects fetch to the CSR-supplied vector through a valid/ready handshake.

Parameters:
- DRAIN_CYCLES, 2, minimum cycles spent in DRAIN before pipe_empty is honoured (covers pipeline depth); legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset; the block is held in reset while reset is 0.
- exc_valid  input  1  writeback reports a synchronous exception this cycle.
- exc_cause  input  4  exception cause code.
- exc_pc  input  32  PC of the faulting instruction.
- mret_valid  input  1  writeback retires an mret this cycle.
- next_pc  input  32  PC of the oldest non-retired instruction; this is ecp for interrupts.
- eip, tip, sip  input  1 each  gated external/timer/software interrupt pending, from the CSR unit.
- pipe_empty  input  1  no valid instruction remains in decode through writeback.
- trap_vector  input  32  trap target from the CSR unit.
- mret_vector  input  32  mret return target from the CSR unit.
- stall  output  1  hold fetch/decode.
- flush  output  1  invalidate all in-flight instructions.
- traped  output  1  one-cycle trap commit pulse to the CSR unit.
- mret  output  1  one-cycle mret commit pulse to the CSR unit.
- ecp  output  32  exception PC to the CSR unit.
- trap_cause  output  4  cause code to the CSR unit.
- interupt  output  1  trap is an interrupt.
- redirect_valid  output  1  fetch redirect request.
- redirect_pc  output  32  fetch redirect target.
- redirect_ready  input  1  fetch accepts the redirect.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: asynchronous and immediate. FSM goes to IDLE and the drain counter to 0. All outputs are 0, including ecp, trap_cause and redirect_pc. Reset mid-sequence abandons the event with no commit pulse.
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE, event arbitration by priority, highest first:
  - exc_valid: latch kind=trap, cause=exc_cause, pc=exc_pc, int=0.
  - mret_valid: latch kind=mret.
  - eip: cause 11, pc=next_pc, int=1.
  - sip: cause 3, pc=next_pc, int=1.
  - tip: cause 7, pc=next_pc, int=1.
  - With any event, go to DRAIN next cycle and clear the counter; otherwise stay in IDLE.
  - Lower-priority simultaneous events are dropped. Interrupts stay pending in the CSR unit and are re-sampled after the sequence.
- DRAIN:
  - stall=1, flush=1; the counter increments and saturates at DRAIN_CYCLES.
  - Go to COMMIT when counter>=DRAIN_CYCLES and pipe_empty=1; otherwise stay.
  - All event inputs are ignored outside IDLE.
- COMMIT: exactly one cycle.
  - stall=1.
  - kind=trap: traped=1 with ecp, trap_cause and interupt driven from the latched values.
  - kind=mret: mret=1; ecp, trap_cause and interupt are 0.
  - Next state is REDIRECT.
- REDIRECT:
  - stall=1, redirect_valid=1.
  - redirect_pc = trap_vector for trap, mret_vector for mret, sampled combinationally in this state (the CSR update has already happened at the COMMIT edge).
  - redirect_valid and redirect_pc stay stable until redirect_ready=1. On that handshake cycle go to IDLE.
- busy = (state != IDLE).
- traped and mret are never 1 in the same cycle, and never 1 outside COMMIT.
- Minimum latency, event to redirect_valid: DRAIN_CYCLES+2 cycles.
- Back-to-back events: an event present in the IDLE cycle right after the handshake is accepted normally.

Optional Feature:
- TRAP_SEQ_COUNT_EN, defined:
  - Adds output trap_count (16 bit), a saturating count of COMMIT cycles with kind=trap.
  - Increments on the COMMIT edge; holds at 16'hffff; asynchronously reset to 0.
- TRAP_SEQ_COUNT_EN undefined: trap_count is present and tied to 0.

Test Plan:
- Exception, DRAIN_CYCLES=2: exc_valid=1, exc_cause=2, exc_pc=0x100, pipe_empty=1.
  - Required: flush/stall for 2 cycles, then traped=1 for 1 cycle with ecp=0x100, trap_cause=2, interupt=0.
  - Then redirect_valid=1 with redirect_pc=trap_vector (0x80).
- Interrupt priority: eip=tip=sip=1, next_pc=0x200.
  - Required: trap_cause=11, interupt=1, ecp=0x200.
  - With only tip=1: trap_cause=7. With sip=tip=1: trap_cause=3.
- Simultaneous exc_valid and mret_valid: traped=1, mret never asserted.
  - mret alone: mret=1 pulse, then redirect_pc=mret_vector (0x344).
- Drain wait: pipe_empty held 0 for 6 cycles.
  - Required: stays in DRAIN with stall=flush=1 and no commit pulse.
  - Commit occurs the cycle after pipe_empty rises.
- Handshake: redirect_ready held 0 for 3 cycles.
  - Required: redirect_valid/redirect_pc stable, busy=1.
  - redirect_ready=1 returns the FSM to IDLE with busy=0 next cycle.
- Reset mid-DRAIN: reset=0 asynchronously.
  - Required: all outputs 0 immediately, no traped pulse after reset=1.
  - trap_count=0 when TRAP_SEQ_COUNT_EN is defined.
